doodle_motion: RTL and testbench



---
 rtl/doodle_pkg.sv | 23 ++
 rtl/doodle_tick_gen.sv | 26 ++
 rtl/doodle_motion.sv | 123 ++++++++++++
 tb/tb_doodle_motion.sv | 128 ++++++++++++
 4 files changed

// File: rtl/doodle_pkg.sv
// Shared doodle constants: screen geometry, doodle size and the one-hot doodle_sm state codes.
// Bit order of a state word is {q_Done, q_Down, q_Up, q_I}.
package doodle_pkg;
    localparam int H_OFFSET      = 144;
    localparam int V_OFFSET      = 35;
    localparam int H_RES         = 630;
    localparam int V_RES         = 480;
    localparam int V_BOTTOM      = 515;
    localparam int DOODLE_RADIUS = 10;

    localparam int POS_W = 10;
    typedef logic [POS_W-1:0] pos_t;
    typedef logic [3:0]       doodle_state_t;

    localparam doodle_state_t I    = 4'b0001;
    localparam doodle_state_t UP   = 4'b0010;
    localparam doodle_state_t DOWN = 4'b0100;
    localparam doodle_state_t DONE = 4'b1000;

    function automatic logic is_one_hot(input doodle_state_t s);
        return (s == I) || (s == UP) || (s == DOWN) || (s == DONE);
    endfunction
endpackage

// File: rtl/doodle_tick_gen.sv
// Free-running divider: o_tick is high for one cycle out of every TICK_DIV (when the count hits TICK_DIV-1).
// Count restarts at 0 on synchronous active-low reset.
module doodle_tick_gen #(
    parameter int TICK_DIV = 250000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] r_cnt;

    assign o_tick = (r_cnt == LAST);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (o_tick)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + ONE;
    end
endmodule

// File: rtl/doodle_motion.sv
// Doodle position generator for doodle_sm: updates x/y/up_count on a divided tick, move_tick one cycle later.
// Optional build macro DOODLE_WRAP_EN: horizontal wrap-around at the walls instead of clamping.
module doodle_motion
    import doodle_pkg::*;
#(
    parameter int TICK_DIV = 250000,
    parameter int X_START  = 459,
    parameter int Y_START  = 495,
    parameter int X_MIN    = 154,
    parameter int X_MAX    = 764,
    parameter int Y_TOP    = 45,
    parameter int H_STEP   = 2
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       q_I,
    input  logic       q_Up,
    input  logic       q_Down,
    input  logic       q_Done,
    input  logic       Left,
    input  logic       Right,
    output logic [9:0] object_x,
    output logic [9:0] object_y,
    output logic [9:0] up_count,
    output logic       move_tick
);
    localparam pos_t XS   = pos_t'(X_START);
    localparam pos_t YS   = pos_t'(Y_START);
    localparam pos_t XMIN = pos_t'(X_MIN);
    localparam pos_t XMAX = pos_t'(X_MAX);
    localparam pos_t YTOP = pos_t'(Y_TOP);
    localparam pos_t STEP = pos_t'(H_STEP);
    localparam pos_t ONE  = pos_t'(1);
    localparam pos_t PMAX = '1;

    logic          w_tick;
    doodle_state_t w_state;
    pos_t          w_x_next;
    pos_t          r_x;
    pos_t          r_y;
    pos_t          r_up;
    logic          r_prev_up;
    logic          r_move_tick;

    doodle_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .i_clk   (Clk),
        .i_rst_n (Reset_n),
        .o_tick  (w_tick)
    );

    assign w_state = {q_Done, q_Down, q_Up, q_I};

    // Compare before stepping so 10-bit arithmetic never wraps through zero or past the wall.
    always_comb begin
        w_x_next = r_x;
        if (Left && !Right) begin
            if (r_x >= XMIN + STEP)
                w_x_next = r_x - STEP;
            else
`ifdef DOODLE_WRAP_EN
                w_x_next = XMAX - (XMIN + STEP - r_x - ONE);
`else
                w_x_next = XMIN;
`endif
        end else if (Right && !Left) begin
            if (r_x <= XMAX - STEP)
                w_x_next = r_x + STEP;
            else
`ifdef DOODLE_WRAP_EN
                w_x_next = XMIN + (r_x + STEP - XMAX - ONE);
`else
                w_x_next = XMAX;
`endif
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_x         <= XS;
            r_y         <= YS;
            r_up        <= '0;
            r_prev_up   <= 1'b0;
            r_move_tick <= 1'b0;
        end else begin
            r_prev_up   <= q_Up;
            r_move_tick <= w_tick;
            case (w_state)
                I: begin
                    r_x  <= XS;
                    r_y  <= YS;
                    r_up <= '0;
                end
                UP: begin
                    // Jump entry wins over a coincident tick so every jump starts from a zero count.
                    if (!r_prev_up) begin
                        r_up <= '0;
                    end else if (w_tick) begin
                        r_x <= w_x_next;
                        if (r_y > YTOP)
                            r_y <= r_y - ONE;
                        if (r_up != PMAX)
                            r_up <= r_up + ONE;
                    end
                end
                DOWN: begin
                    if (w_tick) begin
                        r_x <= w_x_next;
                        if (r_y != PMAX)
                            r_y <= r_y + ONE;
                    end
                end
                default: begin
                    // DONE and non-one-hot inputs freeze the position.
                end
            endcase
        end
    end

    assign object_x  = r_x;
    assign object_y  = r_y;
    assign up_count  = r_up;
    assign move_tick = r_move_tick;
endmodule

// File: tb/tb_doodle_motion.sv
// Directed table-driven bench for doodle_motion with TICK_DIV=4; inputs driven and outputs sampled on negedge.
module tb_doodle_motion;
    import doodle_pkg::*;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       q_I, q_Up, q_Down, q_Done;
    logic       Left, Right;
    logic [9:0] object_x, object_y, up_count;
    logic       move_tick;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    doodle_motion #(.TICK_DIV(4)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .q_I       (q_I),
        .q_Up      (q_Up),
        .q_Down    (q_Down),
        .q_Done    (q_Done),
        .Left      (Left),
        .Right     (Right),
        .object_x  (object_x),
        .object_y  (object_y),
        .up_count  (up_count),
        .move_tick (move_tick)
    );

    typedef struct {
        logic          rst_n;
        doodle_state_t st;
        logic          l;
        logic          r;
        int            cyc;
        int            x;
        int            y;
        int            up;
        logic          mt_care;
        logic          mt;
    } vec_t;

    vec_t vq[$];

    localparam doodle_state_t BAD = 4'b0110;

`ifdef DOODLE_WRAP_EN
    localparam int X14 = 764, X15 = 155, X16 = 764, X17 = 762, X19 = 761, X20 = 763;
`else
    localparam int X14 = 154, X15 = 156, X16 = 154, X17 = 154, X19 = 764, X20 = 764;
`endif

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rst_n, input doodle_state_t st, input logic l, input logic r);
        Reset_n = rst_n;
        {q_Done, q_Down, q_Up, q_I} = st;
        Left  = l;
        Right = r;
    endtask

    initial begin
        //                rst   state l     r     cyc   x    y    up   care  mt
        vq.push_back('{1'b1, I,    1'b0, 1'b0, 4,    459, 495, 0,   1'b1, 1'b1});
        vq.push_back('{1'b1, UP,   1'b0, 1'b0, 40,   459, 485, 10,  1'b1, 1'b1});
        vq.push_back('{1'b1, DOWN, 1'b0, 1'b0, 20,   459, 490, 10,  1'b1, 1'b1});
        vq.push_back('{1'b1, DONE, 1'b1, 1'b0, 80,   459, 490, 10,  1'b0, 1'b0});
        vq.push_back('{1'b1, BAD,  1'b0, 1'b1, 8,    459, 490, 10,  1'b1, 1'b1});
        vq.push_back('{1'b1, I,    1'b0, 1'b0, 3,    459, 495, 0,   1'b1, 1'b0});
        vq.push_back('{1'b1, UP,   1'b0, 1'b0, 1,    459, 495, 0,   1'b1, 1'b1});
        vq.push_back('{1'b1, UP,   1'b0, 1'b0, 4,    459, 494, 1,   1'b1, 1'b1});
        vq.push_back('{1'b1, UP,   1'b0, 1'b0, 1792, 459, 46,  449, 1'b1, 1'b1});
        vq.push_back('{1'b1, UP,   1'b0, 1'b0, 4,    459, 45,  450, 1'b1, 1'b1});
        vq.push_back('{1'b1, UP,   1'b0, 1'b0, 4,    459, 45,  451, 1'b1, 1'b1});
        vq.push_back('{1'b1, UP,   1'b0, 1'b0, 4,    459, 45,  452, 1'b1, 1'b1});
        vq.push_back('{1'b1, UP,   1'b1, 1'b0, 608,  155, 45,  604, 1'b1, 1'b1});
        vq.push_back('{1'b1, UP,   1'b1, 1'b0, 4,    X14, 45,  605, 1'b1, 1'b1});
        vq.push_back('{1'b1, UP,   1'b0, 1'b1, 4,    X15, 45,  606, 1'b1, 1'b1});
        vq.push_back('{1'b1, UP,   1'b1, 1'b0, 4,    X16, 45,  607, 1'b1, 1'b1});
        vq.push_back('{1'b1, UP,   1'b1, 1'b0, 4,    X17, 45,  608, 1'b1, 1'b1});
        vq.push_back('{1'b1, UP,   1'b1, 1'b1, 4,    X17, 45,  609, 1'b1, 1'b1});
        vq.push_back('{1'b1, UP,   1'b0, 1'b1, 1220, X19, 45,  914, 1'b1, 1'b1});
        vq.push_back('{1'b1, UP,   1'b0, 1'b1, 4,    X20, 45,  915, 1'b1, 1'b1});
        vq.push_back('{1'b1, UP,   1'b0, 1'b0, 432,  X20, 45,  1023, 1'b1, 1'b1});
        vq.push_back('{1'b1, UP,   1'b0, 1'b0, 4,    X20, 45,  1023, 1'b1, 1'b1});
        vq.push_back('{1'b1, I,    1'b0, 1'b0, 4,    459, 495, 0,   1'b1, 1'b1});
        vq.push_back('{1'b1, UP,   1'b0, 1'b0, 780,  459, 300, 195, 1'b1, 1'b1});
        vq.push_back('{1'b1, DOWN, 1'b0, 1'b0, 2,    459, 300, 195, 1'b1, 1'b0});
        vq.push_back('{1'b0, DOWN, 1'b0, 1'b0, 1,    459, 495, 0,   1'b1, 1'b0});
        vq.push_back('{1'b1, I,    1'b0, 1'b0, 4,    459, 495, 0,   1'b1, 1'b1});
        vq.push_back('{1'b1, DOWN, 1'b0, 1'b0, 2112, 459, 1023, 0,  1'b1, 1'b1});
        vq.push_back('{1'b1, DOWN, 1'b0, 1'b0, 4,    459, 1023, 0,  1'b1, 1'b1});

        // Reset for two edges, then confirm the first move_tick lands on the 4th edge after release.
        drive(1'b0, I, 1'b0, 1'b0);
        repeat (2) @(negedge Clk);
        check("reset_x",  int'(object_x), 459);
        check("reset_y",  int'(object_y), 495);
        check("reset_up", int'(up_count), 0);
        check("reset_mt", int'(move_tick), 0);
        Reset_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge Clk);
            check($sformatf("release_mt_c%0d", k), int'(move_tick), (k == 4) ? 1 : 0);
        end

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rst_n, vq[i].st, vq[i].l, vq[i].r);
            repeat (vq[i].cyc) @(negedge Clk);
            check($sformatf("row%0d_x", i),  int'(object_x), vq[i].x);
            check($sformatf("row%0d_y", i),  int'(object_y), vq[i].y);
            check($sformatf("row%0d_up", i), int'(up_count), vq[i].up);
            if (vq[i].mt_care)
                check($sformatf("row%0d_mt", i), int'(move_tick), int'(vq[i].mt));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
